// File: rtl/pe_pkg.sv
// Shared types and helpers for the outer-product MAC processing element.
package pe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ISSUE,
        FLUSH,
        DRAIN
    } pe_state_t;

    // Default tile shape: A_NUM x B_NUM accumulators per PE.
    localparam int A_NUM     = 2;
    localparam int B_NUM     = 2;
    localparam int ACC_DEPTH = A_NUM * B_NUM;

    // Accumulator address of the product a_buf[i] * (B word j).
    function automatic int unsigned acc_addr(input int unsigned j,
                                             input int unsigned i,
                                             input int          a_num_width);
        return (j << a_num_width) | i;
    endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// MUL_LAT-stage signed multiplier; address and first-step flag travel with the data.
module pe_mul_pipe #(
    parameter int D_WIDTH = 16,
    parameter int ADDR_W  = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [D_WIDTH-1:0]    in_a,
    input  logic signed [D_WIDTH-1:0]    in_b,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic                         in_first,
    output logic                         out_valid,
    output logic signed [2*D_WIDTH-1:0]  out_prod,
    output logic [ADDR_W-1:0]            out_addr,
    output logic                         out_first
);

    logic [MUL_LAT-1:0]          v_q;
    logic [MUL_LAT-1:0]          first_q;
    logic [ADDR_W-1:0]           addr_q [MUL_LAT];
    logic signed [D_WIDTH-1:0]   a_q;
    logic signed [D_WIDTH-1:0]   b_q;
    logic signed [2*D_WIDTH-1:0] prod_c;

    assign prod_c = a_q * b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q[0] <= in_valid;
            for (int unsigned s = 1; s < MUL_LAT; s++) begin
                v_q[s] <= v_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q        <= in_a;
        b_q        <= in_b;
        addr_q[0]  <= in_addr;
        first_q[0] <= in_first;
        for (int unsigned s = 1; s < MUL_LAT; s++) begin
            addr_q[s]  <= addr_q[s-1];
            first_q[s] <= first_q[s-1];
        end
    end

    // Stage 0 holds the operands; the product is registered in each later stage.
    if (MUL_LAT == 1) begin : g_prod_comb
        assign out_prod = prod_c;
    end else begin : g_prod_pipe
        logic signed [2*D_WIDTH-1:0] p_q [MUL_LAT-1];

        always_ff @(posedge clk) begin
            p_q[0] <= prod_c;
            for (int unsigned s = 1; s < MUL_LAT - 1; s++) begin
                p_q[s] <= p_q[s-1];
            end
        end

        assign out_prod = p_q[MUL_LAT-2];
    end

    assign out_valid = v_q[MUL_LAT-1];
    assign out_addr  = addr_q[MUL_LAT-1];
    assign out_first = first_q[MUL_LAT-1];

endmodule

// File: rtl/pe_mac_tile.sv
// Systolic outer-product MAC tile: loads A/B slices, forwards them east/south,
// accumulates A_NUM x B_NUM products over N k-steps and streams the results out.
module pe_mac_tile
    import pe_pkg::*;
#(
    parameter int D_WIDTH     = 16,
    parameter int ACC_WIDTH   = 48,
    parameter int A_NUM_WIDTH = $clog2(A_NUM),
    parameter int B_NUM_WIDTH = $clog2(B_NUM),
    parameter int N_MAX_WIDTH = 16,
    parameter int MUL_LAT     = 2,
    parameter int PID         = 0,
    parameter bit FWD_EN      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_MAX_WIDTH-1:0] N_in,
    input  logic [D_WIDTH-1:0]     a_in_data,
    input  logic                   a_in_valid,
    output logic                   a_in_ready,
    input  logic [D_WIDTH-1:0]     b_in_data,
    input  logic                   b_in_valid,
    output logic                   b_in_ready,
    output logic [D_WIDTH-1:0]     a_out_data,
    output logic                   a_out_valid,
    input  logic                   a_out_ready,
    output logic [D_WIDTH-1:0]     b_out_data,
    output logic                   b_out_valid,
    input  logic                   b_out_ready,
    output logic [ACC_WIDTH-1:0]   res_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_last,
    output logic [7:0]             pid_out,
    output logic                   busy,
    output logic                   done
);

    localparam int A_CNT  = 1 << A_NUM_WIDTH;
    localparam int B_CNT  = 1 << B_NUM_WIDTH;
    localparam int DEPTH  = A_CNT * B_CNT;
    localparam int AW     = (A_NUM_WIDTH > 0) ? A_NUM_WIDTH : 1;
    localparam int BW     = (B_NUM_WIDTH > 0) ? B_NUM_WIDTH : 1;
    localparam int ADDR_W = (A_NUM_WIDTH + B_NUM_WIDTH > 0) ? A_NUM_WIDTH + B_NUM_WIDTH : 1;
    localparam int FW     = $clog2(MUL_LAT + 1);

    localparam logic [AW-1:0]     A_LAST  = AW'(A_CNT - 1);
    localparam logic [BW-1:0]     B_LAST  = BW'(B_CNT - 1);
    localparam logic [ADDR_W-1:0] D_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [FW-1:0]     FL_LAST = FW'(MUL_LAT);

    if (ACC_WIDTH < 2 * D_WIDTH) begin : g_chk_acc
        $error("ACC_WIDTH must be at least 2*D_WIDTH");
    end
    if (MUL_LAT < 1) begin : g_chk_lat
        $error("MUL_LAT must be at least 1");
    end
    if (DEPTH < MUL_LAT + 2) begin : g_chk_hazard
        $error("A_NUM*B_NUM must be at least MUL_LAT+2");
    end

    pe_state_t              state;
    logic [N_MAX_WIDTH-1:0] n_lat;
    logic [N_MAX_WIDTH-1:0] k;
    logic [N_MAX_WIDTH-1:0] k_nx;
    logic [AW-1:0]          a_idx;
    logic [BW-1:0]          j;
    logic [ADDR_W-1:0]      d;
    logic [ADDR_W-1:0]      d_nx;
    logic [FW-1:0]          fl;
    logic                   zero_job;

    logic [D_WIDTH-1:0]     a_buf [A_CNT];
    logic [D_WIDTH-1:0]     b_reg;
    logic [ACC_WIDTH-1:0]   acc [DEPTH];

    logic                   iss_valid;
    logic [ADDR_W-1:0]      iss_addr;
    logic                   mul_valid;
    logic signed [2*D_WIDTH-1:0] mul_prod;
    logic [ADDR_W-1:0]      mul_addr;
    logic                   mul_first;
    logic [ACC_WIDTH-1:0]   prod_ext;

    logic                   a_fire;
    logic                   b_fire;

    assign a_in_ready = (state == LOAD_A) && (!a_out_valid || a_out_ready || !FWD_EN);
    assign b_in_ready = (state == LOAD_B) && (!b_out_valid || b_out_ready || !FWD_EN);
    assign a_fire     = a_in_valid && a_in_ready;
    assign b_fire     = b_in_valid && b_in_ready;

    assign busy    = (state != IDLE);
    assign pid_out = 8'(PID);
    assign k_nx    = k + 1'b1;
    assign d_nx    = d + 1'b1;

    assign iss_valid = (state == ISSUE);
    assign iss_addr  = ADDR_W'(acc_addr(32'(j), 32'(a_idx), A_NUM_WIDTH));

    pe_mul_pipe #(
        .D_WIDTH (D_WIDTH),
        .ADDR_W  (ADDR_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iss_valid),
        .in_a      (a_buf[a_idx]),
        .in_b      (b_reg),
        .in_addr   (iss_addr),
        .in_first  (k == '0),
        .out_valid (mul_valid),
        .out_prod  (mul_prod),
        .out_addr  (mul_addr),
        .out_first (mul_first)
    );

    assign prod_ext = ACC_WIDTH'(mul_prod);

    // A pending write-back sampled together with rst is dropped, so an aborted job leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && mul_valid) begin
            acc[mul_addr] <= mul_first ? prod_ext : acc[mul_addr] + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n_lat       <= '0;
            k           <= '0;
            a_idx       <= '0;
            j           <= '0;
            d           <= '0;
            fl          <= '0;
            zero_job    <= 1'b0;
            a_out_data  <= '0;
            a_out_valid <= 1'b0;
            b_out_data  <= '0;
            b_out_valid <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            res_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (FWD_EN) begin
                if (a_fire) begin
                    a_out_data  <= a_in_data;
                    a_out_valid <= 1'b1;
                end else if (a_out_ready) begin
                    a_out_valid <= 1'b0;
                end
                if (b_fire) begin
                    b_out_data  <= b_in_data;
                    b_out_valid <= 1'b1;
                end else if (b_out_ready) begin
                    b_out_valid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= N_in;
                        k     <= '0;
                        j     <= '0;
                        a_idx <= '0;
                        d     <= '0;
                        if (N_in == '0) begin
                            zero_job  <= 1'b1;
                            res_valid <= 1'b1;
                            res_data  <= '0;
                            res_last  <= (DEPTH == 1);
                            state     <= DRAIN;
                        end else begin
                            zero_job <= 1'b0;
                            state    <= LOAD_A;
                        end
                    end
                end
                LOAD_A: begin
                    if (a_fire) begin
                        a_buf[a_idx] <= a_in_data;
                        if (a_idx == A_LAST) begin
                            a_idx <= '0;
                            state <= LOAD_B;
                        end else begin
                            a_idx <= a_idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (b_fire) begin
                        b_reg <= b_in_data;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (a_idx == A_LAST) begin
                        a_idx <= '0;
                        if (j != B_LAST) begin
                            j     <= j + 1'b1;
                            state <= LOAD_B;
                        end else begin
                            j <= '0;
                            k <= k_nx;
                            if (k_nx < n_lat) begin
                                state <= LOAD_A;
                            end else begin
                                fl    <= '0;
                                state <= FLUSH;
                            end
                        end
                    end else begin
                        a_idx <= a_idx + 1'b1;
                    end
                end
                FLUSH: begin
                    if (fl == FL_LAST) begin
                        d         <= '0;
                        res_valid <= 1'b1;
                        res_data  <= acc[0];
                        res_last  <= (DEPTH == 1);
                        state     <= DRAIN;
                    end else begin
                        fl <= fl + 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (d == D_LAST) begin
                            res_valid <= 1'b0;
                            res_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            d        <= d_nx;
                            res_data <= zero_job ? '0 : acc[d_nx];
                            res_last <= (d_nx == D_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
